display_pager: RTL and testbench

DISPLAY_PAGER -- requirements
Module: display_pager

---
 rtl/display_pager_pkg.sv | 24 ++
 rtl/display_pager_btn_debounce.sv | 46 ++++
 rtl/display_pager.sv | 103 ++++++++++
 tb/tb_display_pager.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pager_pkg.sv
// Shared display constants: page indices, default timing values and the page-step helper.
package display_pager_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned PAGE_W     = 2;
    localparam int unsigned DEBOUNCE_W = 20;
    localparam int unsigned SCROLL_W   = 28;

    localparam logic [PAGE_W-1:0] PAGE_PC  = 2'd0;
    localparam logic [PAGE_W-1:0] PAGE_IR  = 2'd1;
    localparam logic [PAGE_W-1:0] PAGE_ACC = 2'd2;
    localparam logic [PAGE_W-1:0] PAGE_MAR = 2'd3;

    localparam logic [DEBOUNCE_W-1:0] DEFAULT_DEBOUNCE_CYCLES = 20'd999999;
    localparam logic [SCROLL_W-1:0]   DEFAULT_SCROLL_INTERVAL = 28'd199999999;

    typedef logic [DATA_W-1:0] word_t;

    // Modulo-4 page step; wraps naturally on the 2-bit index.
    function automatic logic [PAGE_W-1:0] page_step(input logic [PAGE_W-1:0] page, input logic up);
        return up ? page + PAGE_W'(1) : page - PAGE_W'(1);
    endfunction

endpackage

// File: rtl/display_pager_btn_debounce.sv
// Button conditioner: two-flop synchronizer, stable-level debounce counter and rising-edge pulse.
module btn_debounce
    import display_pager_pkg::*;
#(
    parameter logic [DEBOUNCE_W-1:0] DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_press
);

    logic                  sync_q1;
    logic                  sync_q2;
    logic                  stable;
    logic                  stable_d;
    logic [DEBOUNCE_W-1:0] cnt;

    // The stable level flips only after DEBOUNCE_CYCLES+1 consecutive differing cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q1  <= 1'b0;
            sync_q2  <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
            o_press  <= 1'b0;
        end else begin
            sync_q1  <= i_btn;
            sync_q2  <= sync_q1;
            stable_d <= stable;
            o_press  <= stable & ~stable_d;
            if (sync_q2 != stable) begin
                if (cnt == DEBOUNCE_CYCLES) begin
                    stable <= sync_q2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + DEBOUNCE_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/display_pager.sv
// Page selector for the seven-segment display word; DISPLAY_PAGER_AUTO_SCROLL_EN adds
// a periodic auto-advance timer.
module display_pager
    import display_pager_pkg::*;
#(
    parameter logic [DEBOUNCE_W-1:0] DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic [SCROLL_W-1:0]   SCROLL_INTERVAL = DEFAULT_SCROLL_INTERVAL
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_btn_next,
    input  logic              i_btn_prev,
    input  logic              i_freeze,
    input  logic [DATA_W-1:0] i_page0,
    input  logic [DATA_W-1:0] i_page1,
    input  logic [DATA_W-1:0] i_page2,
    input  logic [DATA_W-1:0] i_page3,
    output logic [DATA_W-1:0] o_data,
    output logic [PAGE_W-1:0] o_page,
    output logic              o_page_pulse
);

    logic  next_p;
    logic  prev_p;
    logic  scroll_exp_c;
    word_t sel_word_c;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_btn_next),
        .o_press (next_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_btn_prev),
        .o_press (prev_p)
    );

`ifdef DISPLAY_PAGER_AUTO_SCROLL_EN
    logic [SCROLL_W-1:0] scroll_cnt;

    // Any press pulse restarts the timer; freeze holds it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scroll_cnt <= '0;
        end else if (next_p || prev_p) begin
            scroll_cnt <= '0;
        end else if (!i_freeze) begin
            if (scroll_cnt == SCROLL_INTERVAL) begin
                scroll_cnt <= '0;
            end else begin
                scroll_cnt <= scroll_cnt + SCROLL_W'(1);
            end
        end
    end

    assign scroll_exp_c = !i_freeze && (scroll_cnt == SCROLL_INTERVAL);
`else
    logic unused_scroll;
    assign unused_scroll = ^SCROLL_INTERVAL;
    assign scroll_exp_c  = 1'b0;
`endif

    // Presses take priority; coincident next+prev cancel and also swallow a scroll step.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_page       <= PAGE_PC;
            o_page_pulse <= 1'b0;
        end else begin
            o_page_pulse <= 1'b0;
            if (next_p != prev_p) begin
                o_page       <= page_step(o_page, next_p);
                o_page_pulse <= 1'b1;
            end else if (!next_p && scroll_exp_c) begin
                o_page       <= page_step(o_page, 1'b1);
                o_page_pulse <= 1'b1;
            end
        end
    end

    always_comb begin
        sel_word_c = i_page0;
        case (o_page)
            PAGE_PC:  sel_word_c = i_page0;
            PAGE_IR:  sel_word_c = i_page1;
            PAGE_ACC: sel_word_c = i_page2;
            PAGE_MAR: sel_word_c = i_page3;
            default:  sel_word_c = i_page0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data <= '0;
        end else if (!i_freeze) begin
            o_data <= sel_word_c;
        end
    end

endmodule

// File: tb/tb_display_pager.sv
// Self-checking bench for display_pager with DEBOUNCE_CYCLES=4, SCROLL_INTERVAL=20.
module tb_display_pager;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        btn_next = 1'b0;
    logic        btn_prev = 1'b0;
    logic        freeze = 1'b0;
    logic [31:0] pg [4];
    logic [31:0] o_data;
    logic [1:0]  o_page;
    logic        o_page_pulse;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pulses = 0;
    int last_pulse_cyc = 0;
    logic [1:0] exp_q [$];
    logic       data_pending = 1'b0;
    logic [1:0] data_page = 2'd0;

    typedef struct {
        logic       nxt;
        logic       prv;
        logic       pulse;
        logic [1:0] page;
    } vec_t;
    vec_t vecs [9];

    display_pager #(.DEBOUNCE_CYCLES(20'd4), .SCROLL_INTERVAL(28'd20)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_btn_next   (btn_next),
        .i_btn_prev   (btn_prev),
        .i_freeze     (freeze),
        .i_page0      (pg[0]),
        .i_page1      (pg[1]),
        .i_page2      (pg[2]),
        .i_page3      (pg[3]),
        .o_data       (o_data),
        .o_page       (o_page),
        .o_page_pulse (o_page_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Scoreboard monitor: every page pulse pops one expected page; o_data checked a cycle later.
    always @(negedge clk) begin
        if (data_pending) begin
            chk("data_track", o_data, pg[data_page]);
            data_pending = 1'b0;
        end
        if (rst_n && o_page_pulse) begin
            pulses++;
            last_pulse_cyc = cyc;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse got_page=%0d want=no_pulse", o_page);
            end else begin
                chk("pulse_page", 32'(o_page), 32'(exp_q.pop_front()));
            end
            data_pending = !freeze;
            data_page    = o_page;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clean press-and-release; a pulse is expected exactly 9 cycles after the press.
    task automatic press(input logic n, input logic p, input logic exp_pulse, input logic [1:0] exp_page);
        int c0;
        int p0;
        c0 = cyc;
        p0 = pulses;
        if (exp_pulse) exp_q.push_back(exp_page);
        btn_next = n;
        btn_prev = p;
        tick(14);
        chk("press_count", 32'(pulses - p0), exp_pulse ? 32'd1 : 32'd0);
        if (exp_pulse) chk("press_latency", 32'(last_pulse_cyc - c0), 32'd9);
        chk("press_page", 32'(o_page), 32'(exp_page));
        btn_next = 1'b0;
        btn_prev = 1'b0;
        tick(12);
        chk("release_no_pulse", 32'(pulses - p0), exp_pulse ? 32'd1 : 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int c0;
        vecs[0] = '{1'b1, 1'b0, 1'b1, 2'd1};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 2'd2};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 2'd3};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 2'd0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 2'd3};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 2'd3};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 2'd0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 2'd3};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 2'd2};
        pg[0] = 32'hA000_0000;
        pg[1] = 32'hB111_1111;
        pg[2] = 32'hC222_2222;
        pg[3] = 32'hD333_3333;

        // Reset held with both buttons toggling.
        #2 rst_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            btn_next = i[0];
            btn_prev = ~i[0];
            tick(1);
            chk("rst_page", 32'(o_page), 32'd0);
            chk("rst_data", o_data, 32'd0);
            chk("rst_pulse", 32'(o_page_pulse), 32'd0);
        end
        btn_next = 1'b0;
        btn_prev = 1'b0;
        tick(1);
        rst_n = 1'b1;

`ifdef DISPLAY_PAGER_AUTO_SCROLL_EN
        // Idle auto-scroll, then a press that restarts the timer.
        c0 = cyc;
        p0 = pulses;
        exp_q.push_back(2'd1);
        tick(25);
        chk("scroll_count", 32'(pulses - p0), 32'd1);
        chk("scroll_period", 32'(last_pulse_cyc - c0), 32'd21);
        c0 = last_pulse_cyc;
        while (cyc < c0 + 6) tick(1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        btn_next = 1'b1;
        tick(14);
        chk("scroll_press_count", 32'(pulses - p0), 32'd2);
        chk("scroll_press_cyc", 32'(last_pulse_cyc - c0), 32'd15);
        btn_next = 1'b0;
        tick(20);
        chk("scroll_restart_count", 32'(pulses - p0), 32'd3);
        chk("scroll_restart_cyc", 32'(last_pulse_cyc - c0), 32'd36);
        chk("scroll_page", 32'(o_page), 32'd3);
`else
        // Reset in the middle of a debounce count discards it.
        p0 = pulses;
        tick(2);
        btn_next = 1'b1;
        tick(5);
        rst_n = 1'b0;
        btn_next = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(15);
        chk("rst_mid_debounce_pulses", 32'(pulses - p0), 32'd0);
        chk("rst_mid_debounce_page", 32'(o_page), 32'd0);

        for (int i = 0; i < 9; i++) begin
            press(vecs[i].nxt, vecs[i].prv, vecs[i].pulse, vecs[i].page);
        end

        // Bouncing next button: one pulse, counted from the last edge.
        p0 = pulses;
        exp_q.push_back(2'd3);
        for (int k = 0; k < 10; k++) begin
            btn_next = (k % 2 == 0);
            tick(2);
        end
        c0 = cyc;
        btn_next = 1'b1;
        tick(14);
        chk("bounce_count", 32'(pulses - p0), 32'd1);
        chk("bounce_latency", 32'(last_pulse_cyc - c0), 32'd9);
        chk("bounce_page", 32'(o_page), 32'd3);
        btn_next = 1'b0;
        tick(12);
        chk("bounce_release", 32'(pulses - p0), 32'd1);

        // Freeze holds o_data; release resumes on the next clock.
        press(1'b1, 1'b0, 1'b1, 2'd0);
        pg[0] = 32'hDEAD_BEEF;
        tick(2);
        chk("freeze_pre", o_data, 32'hDEAD_BEEF);
        freeze = 1'b1;
        tick(1);
        pg[0] = 32'h1234_5678;
        tick(3);
        chk("freeze_hold", o_data, 32'hDEAD_BEEF);
        freeze = 1'b0;
        tick(1);
        chk("freeze_release", o_data, 32'h1234_5678);
        freeze = 1'b1;
        press(1'b1, 1'b0, 1'b1, 2'd1);
        chk("freeze_press_hold", o_data, 32'h1234_5678);
        freeze = 1'b0;
        tick(1);
        chk("freeze_press_release", o_data, pg[1]);

        // No auto-scroll in this build.
        p0 = pulses;
        tick(40);
        chk("idle_no_scroll", 32'(pulses - p0), 32'd0);
        chk("idle_page", 32'(o_page), 32'd1);
`endif

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
